// File: rtl/sp_ram_arb_pkg.sv
// Shared types and constants for the two-master single-port RAM arbiter.
// Optional feature macro: SP_RAM_ARB_RR_EN (round-robin between masters in ARB).
package sp_ram_arb_pkg;

  localparam int unsigned NUM_MASTERS = 2;

  // Arbiter FSM state encoding, kept as plain constants for legacy tooling.
  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ST_ARB  = 1'b0;
  localparam arb_state_t ST_LOCK = 1'b1;

  // Index of a master (0 = core data port, 1 = accelerator loader).
  typedef logic master_idx_t;

endpackage

// File: rtl/rr_arb_2.sv
// Two-input request arbiter.
// With SP_RAM_ARB_RR_EN defined, a pointer register picks the winner on contention
// and flips to the loser after every contended grant. Without it, input 0 always
// wins and no state exists (clock/reset ports are then omitted).
module rr_arb_2
  import sp_ram_arb_pkg::*;
(
`ifdef SP_RAM_ARB_RR_EN
  input  logic                   clk,
  input  logic                   rst_i,
`endif
  input  logic                   en_i,
  input  logic [NUM_MASTERS-1:0] req_i,
  output logic [NUM_MASTERS-1:0] gnt_o
);

`ifdef SP_RAM_ARB_RR_EN
  master_idx_t ptr_q;

  // Grant follows the pointer only when both inputs request.
  always_comb begin
    gnt_o    = '0;
    gnt_o[0] = en_i & req_i[0] & (~req_i[1] | ~ptr_q);
    gnt_o[1] = en_i & req_i[1] & (~req_i[0] | ptr_q);
  end

  // Pointer moves to the non-winner after a contended, enabled grant.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else if (en_i && (&req_i)) begin
      ptr_q <= ~gnt_o[1];
    end
  end
`else
  // Fixed priority: input 0 always wins.
  always_comb begin
    gnt_o    = '0;
    gnt_o[0] = en_i & req_i[0];
    gnt_o[1] = en_i & req_i[1] & ~req_i[0];
  end
`endif

endmodule

// File: rtl/sp_ram_arbiter.sv
// Arbiter sharing the single-port data RAM between the core data port (master 0)
// and the accelerator loader (master 1). Grants are combinational; the response
// valid is registered one cycle after grant. Master 1 may hold the RAM via lock
// for up to MAX_LOCK consecutive grants.
// Optional feature macro: SP_RAM_ARB_RR_EN (round-robin instead of fixed priority).
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_LOCK   = 16
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  input  logic                    m1_lock_i,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int unsigned CNT_WIDTH = $clog2(MAX_LOCK + 1);

  arb_state_t             state_q, state_d;
  logic [CNT_WIDTH-1:0]   lock_cnt_q, lock_cnt_d, lock_cnt_inc;
  logic [NUM_MASTERS-1:0] req, arb_gnt, gnt;
  logic                   arb_en;
  logic                   rsp_valid_q;
  master_idx_t            rsp_owner_q;

  logic [ADDR_WIDTH-1:0]   hold_addr_q, sel_addr;
  logic                    hold_we_q, sel_we;
  logic [DATA_WIDTH/8-1:0] hold_be_q, sel_be;
  logic [DATA_WIDTH-1:0]   hold_wdata_q, sel_wdata;

  assign req    = {m1_req_i, m0_req_i};
  assign arb_en = (state_q == ST_ARB) && !rst_i;

  rr_arb_2 u_arb (
`ifdef SP_RAM_ARB_RR_EN
    .clk   (clk),
    .rst_i (rst_i),
`endif
    .en_i  (arb_en),
    .req_i (req),
    .gnt_o (arb_gnt)
  );

  // Saturating increment so the counter never wraps.
  assign lock_cnt_inc = (lock_cnt_q == CNT_WIDTH'(MAX_LOCK)) ? lock_cnt_q : lock_cnt_q + 1'b1;

  // Grant selection and lock FSM next state; nothing is granted while in reset.
  always_comb begin
    gnt        = '0;
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (!rst_i) begin
      unique case (state_q)
        ST_ARB: begin
          gnt = arb_gnt;
          // A lock limit of one grant never needs the LOCK state.
          if (arb_gnt[1] && m1_lock_i && (MAX_LOCK > 1)) begin
            state_d    = ST_LOCK;
            lock_cnt_d = CNT_WIDTH'(1);
          end
        end
        ST_LOCK: begin
          if (m1_req_i) begin
            gnt[1]     = 1'b1;
            lock_cnt_d = lock_cnt_inc;
            if (!m1_lock_i || (lock_cnt_inc >= CNT_WIDTH'(MAX_LOCK))) begin
              state_d    = ST_ARB;
              lock_cnt_d = '0;
            end
          end else begin
            state_d    = ST_ARB;
            lock_cnt_d = '0;
          end
        end
        default: state_d = ST_ARB;
      endcase
    end
  end

  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];

  // Winner's request fields, or the last driven values when idle.
  always_comb begin
    sel_addr  = gnt[1] ? m1_addr_i  : m0_addr_i;
    sel_we    = gnt[1] ? m1_we_i    : m0_we_i;
    sel_be    = gnt[1] ? m1_be_i    : m0_be_i;
    sel_wdata = gnt[1] ? m1_wdata_i : m0_wdata_i;
    ram_en_o  = |gnt;
    if (|gnt) begin
      ram_addr_o  = sel_addr;
      ram_we_o    = sel_we;
      ram_be_o    = sel_be;
      ram_wdata_o = sel_wdata;
    end else begin
      ram_addr_o  = hold_addr_q;
      ram_we_o    = hold_we_q;
      ram_be_o    = hold_be_q;
      ram_wdata_o = hold_wdata_q;
    end
  end

  // State, lock counter, response tracking and held RAM request fields.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q      <= ST_ARB;
      lock_cnt_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_owner_q  <= 1'b0;
      hold_addr_q  <= '0;
      hold_we_q    <= 1'b0;
      hold_be_q    <= '0;
      hold_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      rsp_valid_q <= |gnt;
      rsp_owner_q <= gnt[1];
      if (|gnt) begin
        hold_addr_q  <= sel_addr;
        hold_we_q    <= sel_we;
        hold_be_q    <= sel_be;
        hold_wdata_q <= sel_wdata;
      end
    end
  end

  assign m0_rvalid_o = rsp_valid_q & (rsp_owner_q == 1'b0);
  assign m1_rvalid_o = rsp_valid_q & (rsp_owner_q == 1'b1);
  assign m0_rdata_o  = ram_rdata_i;
  assign m1_rdata_o  = ram_rdata_i;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: directed per-cycle stimulus with hand-computed grants;
// expected responses go into a scoreboard queue that a negedge monitor drains.
module tb_sp_ram_arbiter;

  typedef struct {
    bit          owner;
    bit          is_write;
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0, m1_lock = 1'b0;
  logic [14:0] m0_addr = '0, m1_addr = '0;
  logic        m0_we = 1'b0, m1_we = 1'b0;
  logic [3:0]  m0_be = 4'hF, m1_be = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en, ram_we;
  logic [14:0] ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  rsp_t sb[$];

  logic [14:0] last_addr = '0;
  logic        last_we = 1'b0;
  logic [3:0]  last_be = '0;
  logic [31:0] last_wdata = '0;

  sp_ram_arbiter dut (
    .clk         (clk),
    .rst_i       (rst),
    .m0_req_i    (m0_req),
    .m0_gnt_o    (m0_gnt),
    .m0_addr_i   (m0_addr),
    .m0_we_i     (m0_we),
    .m0_be_i     (m0_be),
    .m0_wdata_i  (m0_wdata),
    .m0_rvalid_o (m0_rvalid),
    .m0_rdata_o  (m0_rdata),
    .m1_req_i    (m1_req),
    .m1_gnt_o    (m1_gnt),
    .m1_addr_i   (m1_addr),
    .m1_we_i     (m1_we),
    .m1_be_i     (m1_be),
    .m1_wdata_i  (m1_wdata),
    .m1_rvalid_o (m1_rvalid),
    .m1_rdata_o  (m1_rdata),
    .m1_lock_i   (m1_lock),
    .ram_en_o    (ram_en),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [14:0] a);
    return (a == 15'h100) ? 32'hDEADBEEF : (32'hC0DE0000 ^ {17'd0, a});
  endfunction

  // Simple RAM: one-cycle read latency on whatever address the arbiter presents.
  always @(posedge clk) begin
    if (ram_en && !ram_we) ram_rdata <= pat(ram_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of requests, check the same-cycle grant and RAM port, and
  // queue the response the winner should see one cycle later.
  task automatic step(input bit r0, input bit r1, input bit lk,
                      input logic [14:0] a0, input logic [14:0] a1,
                      input bit we1, input logic [3:0] be1, input logic [31:0] wd1,
                      input bit e0, input bit e1, input string tag);
    rsp_t r;
    @(posedge clk);
    #1;
    m0_req = r0; m1_req = r1; m1_lock = lk;
    m0_addr = a0; m1_addr = a1; m1_we = we1; m1_be = be1; m1_wdata = wd1;
    #1;
    chk({tag, ".m0_gnt"}, {31'd0, m0_gnt}, {31'd0, e0});
    chk({tag, ".m1_gnt"}, {31'd0, m1_gnt}, {31'd0, e1});
    chk({tag, ".ram_en"}, {31'd0, ram_en}, {31'd0, e0 | e1});
    if (e0) begin
      last_addr = a0; last_we = 1'b0; last_be = 4'hF; last_wdata = 32'd0;
    end else if (e1) begin
      last_addr = a1; last_we = we1; last_be = be1; last_wdata = wd1;
    end
    chk({tag, ".ram_addr"}, {17'd0, ram_addr}, {17'd0, last_addr});
    chk({tag, ".ram_we"}, {31'd0, ram_we}, {31'd0, last_we});
    chk({tag, ".ram_be"}, {28'd0, ram_be}, {28'd0, last_be});
    chk({tag, ".ram_wdata"}, ram_wdata, last_wdata);
    if (e0 || e1) begin
      r.owner    = e1;
      r.is_write = e1 && we1;
      r.due      = cyc + 1;
      r.data     = pat(e1 ? a1 : a0);
      sb.push_back(r);
    end
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 1'b0, 15'h0, 15'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, tag);
  endtask

  // Monitor: compare presented responses against the scoreboard head.
  always @(negedge clk) begin
    rsp_t       ent;
    logic [1:0] exp_v;
    exp_v = 2'b00;
    ent.owner = 1'b0; ent.is_write = 1'b0; ent.due = 0; ent.data = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      ent = sb.pop_front();
      exp_v[ent.owner] = 1'b1;
    end
    if (exp_v != 2'b00 || m0_rvalid || m1_rvalid) begin
      chk("rvalid", {30'd0, m1_rvalid, m0_rvalid}, {30'd0, exp_v});
      if (exp_v != 2'b00 && !ent.is_write) begin
        chk("rdata", ent.owner ? m1_rdata : m0_rdata, ent.data);
      end
    end
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk("rst.rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("rst.ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst.ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst.ram_addr", {17'd0, ram_addr}, 32'd0);
    rst = 1'b0;

    // Single m0 read of 0x100, then idle: RAM fields hold the last request.
    step(1'b1, 1'b0, 1'b0, 15'h100, 15'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, "rd0");
    idle("rd0_idle");
    idle("rd0_idle2");

    // Four cycles of continuous contention.
    for (int i = 0; i < 4; i++) begin
`ifdef SP_RAM_ARB_RR_EN
      step(1'b1, 1'b1, 1'b0, 15'h010, 15'h020, 1'b0, 4'hF, 32'h0,
           (i % 2) == 0, (i % 2) == 1, "contend");
`else
      step(1'b1, 1'b1, 1'b0, 15'h010, 15'h020, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, "contend");
`endif
    end
    idle("contend_idle");

    // Lock held to the limit: 16 m1 grants, then m0 wins.
    step(1'b0, 1'b1, 1'b1, 15'h030, 15'h044, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, "lock_first");
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b1, 1'b1, 15'h030, 15'h044 + 15'(4 * i), 1'b0, 4'hF, 32'h0,
           1'b0, 1'b1, "lock_hold");
    end
    step(1'b1, 1'b1, 1'b1, 15'h030, 15'h080, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, "lock_limit");
    idle("lock_idle");

    // Lock dropped on the third grant: master 0 gets the fourth cycle.
    step(1'b0, 1'b1, 1'b1, 15'h050, 15'h060, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, "drop1");
    step(1'b1, 1'b1, 1'b1, 15'h050, 15'h064, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, "drop2");
    step(1'b1, 1'b1, 1'b0, 15'h050, 15'h068, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, "drop3");
    step(1'b1, 1'b0, 1'b0, 15'h050, 15'h068, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, "drop4");
    idle("drop_idle");

    // m1 partial write.
    step(1'b0, 1'b1, 1'b0, 15'h000, 15'h040, 1'b1, 4'b0011, 32'h12345678,
         1'b0, 1'b1, "wr1");
    idle("wr1_idle");

    // Reset right after an m0 read grant: nothing granted under reset, then all clear.
    step(1'b1, 1'b0, 1'b0, 15'h200, 15'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, "pre_rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("in_rst.gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk("in_rst.ram_en", {31'd0, ram_en}, 32'd0);
    @(posedge clk);
    #1;
    m0_req = 1'b0;
    #1;
    chk("post_rst.rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("post_rst.ram_en", {31'd0, ram_en}, 32'd0);
    chk("post_rst.ram_we", {31'd0, ram_we}, 32'd0);
    chk("post_rst.ram_addr", {17'd0, ram_addr}, 32'd0);
    chk("post_rst.ram_be", {28'd0, ram_be}, 32'd0);
    chk("post_rst.ram_wdata", ram_wdata, 32'd0);
    rst = 1'b0;
    last_addr = '0; last_we = 1'b0; last_be = '0; last_wdata = '0;
    idle("after_rst");

    repeat (3) @(posedge clk);
    #2;
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
